// File: rtl/pmux_pipe_tree.sv
// pmux_pipe_tree: pipelined N:1 multiplexer built as a radix-4 tree.
// N = 2**sel_width inputs. There are sel_width/2 levels, and each level
// is followed by a register stage. Level k picks one of four candidates
// using select bits [2k-1:2k-2], starting with the LSB pair at level 1.
// The full select index travels with the data so it can serve as a tag.
//
// Handshake: a transfer happens on a rising edge when valid && ready.
// The whole pipeline stalls while out_valid && !out_ready. In that case
// every stage register holds its value and in_ready is low. At all other
// times every stage advances by one level. Bubbles advance as well and
// are never collapsed. The only combinational path from an input to an
// output is out_ready -> in_ready.
module pmux_pipe_tree #(
   parameter int width     = 8,
   parameter int sel_width = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [(2**sel_width)*width-1:0]   in_data,
   input  logic [sel_width-1:0]              in_sel,
   input  logic                              in_valid,
   output logic                              in_ready,
   output logic [width-1:0]                  out_data,
   output logic [sel_width-1:0]              out_sel,
   output logic                              out_valid,
   input  logic                              out_ready
);

   localparam int n      = 2**sel_width;
   localparam int levels = sel_width / 2;

   // The radix-4 tree only works for an even select width of at most 8.
   if ((sel_width % 2) != 0 || sel_width < 2 || sel_width > 8) begin : g_bad_param
      $error("pmux_pipe_tree: sel_width must be even and in 2..8");
   end

   logic stall;

   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;

   for (genvar k = 1; k <= levels; k++) begin : lvl
      localparam int cnt      = n >> (2*k);
      localparam int prev_cnt = cnt * 4;

      logic [prev_cnt*width-1:0] src_data;
      logic [sel_width-1:0]      src_sel;
      logic                      src_valid;
      logic [1:0]                pick;
      logic [cnt*width-1:0]      data_d;
      logic [cnt*width-1:0]      data_q;
      logic [sel_width-1:0]      sel_q;
      logic                      valid_q;

      if (k == 1) begin : g_src_in
         assign src_data  = in_data;
         assign src_sel   = in_sel;
         assign src_valid = in_valid;
      end else begin : g_src_lvl
         assign src_data  = lvl[k-1].data_q;
         assign src_sel   = lvl[k-1].sel_q;
         assign src_valid = lvl[k-1].valid_q;
      end

      assign pick = src_sel[2*k-1 -: 2];

      // 4:1 selection for every group of four candidates at this level.
      always_comb begin
         data_d = '0;
         for (int j = 0; j < cnt; j++) begin
            data_d[j*width +: width] = src_data[(4*j + int'(pick))*width +: width];
         end
      end

      // Stage register. It holds its value on a stall and clears to 0 on reset.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            data_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
         end else if (!stall) begin
            data_q  <= data_d;
            sel_q   <= src_sel;
            valid_q <= src_valid;
         end
      end
   end

   assign out_data  = lvl[levels].data_q;
   assign out_sel   = lvl[levels].sel_q;
   assign out_valid = lvl[levels].valid_q;

endmodule

// File: tb/tb_pmux_pipe_tree.sv
// Directed testbench for pmux_pipe_tree. The main instance uses width=8
// and sel_width=4, so it has 2 levels. A second instance uses width=32 and
// sel_width=2, so it has 1 level.
module tb_pmux_pipe_tree;

   logic          clk;
   logic          rst;
   logic [127:0]  in_data;
   logic [3:0]    in_sel;
   logic          in_valid;
   logic          in_ready;
   logic [7:0]    out_data;
   logic [3:0]    out_sel;
   logic          out_valid;
   logic          out_ready;

   logic [127:0]  w_in_data;
   logic [1:0]    w_in_sel;
   logic          w_in_valid;
   logic          w_in_ready;
   logic [31:0]   w_out_data;
   logic [1:0]    w_out_sel;
   logic          w_out_valid;
   logic          w_out_ready;

   int total;
   int bad;

   pmux_pipe_tree #(.width(8), .sel_width(4)) u_dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
      .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
      .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready)
   );

   pmux_pipe_tree #(.width(32), .sel_width(2)) u_dut_w (
      .clk(clk), .rst(rst), .in_data(w_in_data), .in_sel(w_in_sel),
      .in_valid(w_in_valid), .in_ready(w_in_ready), .out_data(w_out_data),
      .out_sel(w_out_sel), .out_valid(w_out_valid), .out_ready(w_out_ready)
   );

   // Clock generation.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Wait for one rising edge, then 1 time unit, so outputs are sampled
   // and inputs driven away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_default_inputs();
      for (int i = 0; i < 16; i++) in_data[i*8 +: 8] = 8'h10 + 8'(i);
   endtask

   // Push idle cycles until the pipeline is empty.
   task automatic flush();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      step();
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0; in_sel = '0; out_ready = 1'b1;
      w_in_valid = 1'b0; w_in_sel = '0; w_out_ready = 1'b1; w_in_data = '0;
      set_default_inputs();
      #3;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
      total++; if (out_sel !== 4'h0) begin bad++; $display("FAIL reset_out_sel got=%h exp=0", out_sel); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      total++; if (w_out_valid !== 1'b0 || w_out_data !== 32'h0) begin bad++; $display("FAIL reset_w_out got=%b/%h exp=0/0", w_out_valid, w_out_data); end
      step();
      step();
      rst = 1'b0;
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_valid got=%b exp=0", out_valid); end
   endtask

   task automatic test_sweep();
      set_default_inputs();
      out_ready = 1'b1;
      for (int s = 0; s <= 16; s++) begin
         in_valid = (s < 16);
         in_sel   = 4'(s);
         step();
         if (s == 0) begin
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sweep_latency got=%b exp=0", out_valid); end
         end else begin
            total++;
            if (out_valid !== 1'b1 || out_sel !== 4'(s-1) || out_data !== 8'h10 + 8'(s-1)) begin
               bad++;
               $display("FAIL sweep_beat%0d got=%b/%h/%h exp=1/%h/%h", s-1, out_valid, out_sel, out_data, 4'(s-1), 8'h10 + 8'(s-1));
            end
         end
      end
      in_valid = 1'b0;
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sweep_drain got=%b exp=0", out_valid); end
   endtask

   task automatic test_backpressure();
      flush();
      in_valid = 1'b1; in_sel = 4'd5;
      step();
      in_sel = 4'd10;
      step();
      // Item 5 is at the output and item 10 is in stage 1. Stall now, and
      // offer item 12, which must wait.
      out_ready = 1'b0;
      in_sel = 4'd12;
      #1;
      for (int c = 0; c < 4; c++) begin
         total++;
         if (out_valid !== 1'b1 || out_data !== 8'h15 || out_sel !== 4'd5 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL stall_hold%0d got=%b/%h/%h rdy=%b exp=1/15/5 rdy=0", c, out_valid, out_data, out_sel, in_ready);
         end
         step();
      end
      out_ready = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
      step();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1 || out_data !== 8'h1A || out_sel !== 4'd10) begin bad++; $display("FAIL release_second got=%b/%h/%h exp=1/1a/a", out_valid, out_data, out_sel); end
      step();
      total++; if (out_valid !== 1'b1 || out_data !== 8'h1C || out_sel !== 4'd12) begin bad++; $display("FAIL held_input got=%b/%h/%h exp=1/1c/c", out_valid, out_data, out_sel); end
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL no_duplicate got=%b exp=0", out_valid); end
   endtask

   task automatic test_bubbles();
      flush();
      in_sel = 4'd3;
      for (int s = 0; s <= 8; s++) begin
         in_valid = (s < 8) && (s % 2 == 0);
         step();
         if (s >= 1) begin
            total++;
            if (out_valid !== ((s-1) % 2 == 0)) begin
               bad++;
               $display("FAIL bubble_valid%0d got=%b exp=%b", s, out_valid, ((s-1) % 2 == 0));
            end else if (out_valid && out_data !== 8'h13) begin
               bad++;
               $display("FAIL bubble_data%0d got=%h exp=13", s, out_data);
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_edges();
      logic [7:0] exp_d [3];
      logic [3:0] sels [3];
      sels[0] = 4'd15; exp_d[0] = 8'hFF;
      sels[1] = 4'd0;  exp_d[1] = 8'hFF;
      sels[2] = 4'd1;  exp_d[2] = 8'h00;
      flush();
      for (int t = 0; t < 3; t++) begin
         in_data = '0;
         if (t == 0) in_data[127:120] = 8'hFF;
         else        in_data[7:0]     = 8'hFF;
         in_valid = 1'b1; in_sel = sels[t];
         step();
         in_valid = 1'b0;
         step();
         total++;
         if (out_valid !== 1'b1 || out_data !== exp_d[t] || out_sel !== sels[t]) begin
            bad++;
            $display("FAIL edge%0d got=%b/%h/%h exp=1/%h/%h", t, out_valid, out_data, out_sel, exp_d[t], sels[t]);
         end
         step();
      end
      set_default_inputs();
   endtask

   task automatic test_async_reset();
      flush();
      in_valid = 1'b1; in_sel = 4'd1;
      step();
      in_sel = 4'd2;
      step();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin bad++; $display("FAIL pre_reset_item got=%b/%h exp=1/11", out_valid, out_data); end
      #2;
      rst = 1'b1;
      #1;
      total++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 4'h0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL async_reset got=%b/%h/%h rdy=%b exp=0/00/0 rdy=1", out_valid, out_data, out_sel, in_ready);
      end
      step();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_hold_ready got=%b exp=1", in_ready); end
      rst = 1'b0;
      step();
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stale_item got=%b exp=0", out_valid); end
      in_valid = 1'b1; in_sel = 4'd7;
      step();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL restart_early got=%b exp=0", out_valid); end
      step();
      total++; if (out_valid !== 1'b1 || out_data !== 8'h17 || out_sel !== 4'd7) begin bad++; $display("FAIL restart_item got=%b/%h/%h exp=1/17/7", out_valid, out_data, out_sel); end
   endtask

   task automatic test_wide_build();
      w_in_data = {32'hDEADBEEF, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
      w_out_ready = 1'b1;
      w_in_valid = 1'b1; w_in_sel = 2'd3;
      #1;
      total++; if (w_out_valid !== 1'b0) begin bad++; $display("FAIL wide_idle got=%b exp=0", w_out_valid); end
      step();
      w_in_sel = 2'd1;
      total++; if (w_out_valid !== 1'b1 || w_out_data !== 32'hDEADBEEF || w_out_sel !== 2'd3) begin bad++; $display("FAIL wide_sel3 got=%b/%h/%h exp=1/deadbeef/3", w_out_valid, w_out_data, w_out_sel); end
      step();
      w_in_valid = 1'b0;
      total++; if (w_out_valid !== 1'b1 || w_out_data !== 32'h1111_1111 || w_out_sel !== 2'd1) begin bad++; $display("FAIL wide_sel1 got=%b/%h/%h exp=1/11111111/1", w_out_valid, w_out_data, w_out_sel); end
      step();
      total++; if (w_out_valid !== 1'b0) begin bad++; $display("FAIL wide_drain got=%b exp=0", w_out_valid); end
   endtask

   // Run the scenarios in order, then print the summary.
   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_sweep();
      test_backpressure();
      test_bubbles();
      test_edges();
      test_async_reset();
      test_wide_build();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
